// File: rtl/apu_mix_pkg.sv
// apu_mix_pkg: shared types and constants for the APU stereo mix sequencer.
// Optional build macro used by the top level: APU_MIX_PEAK_EN.
package apu_mix_pkg;

    localparam int AMP_W     = 4;
    localparam int LVL_W     = 3;
    localparam int TERM_W    = 7;
    localparam int MIX_STEPS = 8;

    // Channel indices, also the value of step[2:1] while that channel is mixed.
    localparam logic [1:0] CH_PULSE1  = 2'd0;
    localparam logic [1:0] CH_PULSE2  = 2'd1;
    localparam logic [1:0] CH_PATTERN = 2'd2;
    localparam logic [1:0] CH_NOISE   = 2'd3;

    typedef logic [2:0] step_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mix_state_t;

    // Everything a mix needs, captured on the accepting edge.
    typedef struct packed {
        logic [4*AMP_W-1:0] amp;
        logic [LVL_W-1:0]   lvl_so2;
        logic [LVL_W-1:0]   lvl_so1;
        logic [7:0]         dst;
    } mix_snap_t;

    // Pick one channel's 4-bit amplitude out of the packed amplitude word.
    function automatic logic [AMP_W-1:0] amp_of(input logic [4*AMP_W-1:0] amps,
                                                input logic [1:0]         ch);
        logic [AMP_W-1:0] a;
        case (ch)
            CH_PULSE1:  a = amps[3:0];
            CH_PULSE2:  a = amps[7:4];
            CH_PATTERN: a = amps[11:8];
            default:    a = amps[15:12];
        endcase
        return a;
    endfunction

endpackage

// File: rtl/mix_term_mul.sv
// mix_term_mul: one gated, scaled mix term, (lvl + 1) * amp when enabled.
// Purely combinational; a single instance is time-shared by the sequencer.
module mix_term_mul
    import apu_mix_pkg::*;
(
    input  logic [AMP_W-1:0]  amp,
    input  logic [LVL_W-1:0]  lvl,
    input  logic              en,
    output logic [TERM_W-1:0] term
);

    logic [3:0]        w_lvl_p1;
    logic [TERM_W-1:0] w_prod;

    // lvl + 1 spans 1..8, so one extra bit is needed before multiplying.
    assign w_lvl_p1 = {1'b0, lvl} + 4'd1;
    // Largest product is 8 * 15 = 120, which fits in TERM_W bits.
    assign w_prod   = TERM_W'(w_lvl_p1) * TERM_W'(amp);
    assign term     = en ? w_prod : '0;

endmodule

// File: rtl/apu_mix_sequencer.sv
// apu_mix_sequencer: time-multiplexed stereo mixer for the APU output stage.
// Snapshots amplitudes/volume/panning on a request, runs 8 multiply steps
// through one shared multiplier, then publishes SO1/SO2 with a valid strobe.
// Optional build macro: APU_MIX_PEAK_EN adds per-side peak-hold registers.
module apu_mix_sequencer
    import apu_mix_pkg::*;
#(
    parameter int SUM_W = 9,
    parameter int STEPS = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             sample_req,
    input  logic [15:0]      ch_amp,
    input  logic [7:0]       ch_volume,
    input  logic [7:0]       ch_dst,
    input  logic             ovr_clr,
`ifdef APU_MIX_PEAK_EN
    input  logic             peak_clr,
    output logic [SUM_W-1:0] peak_so1,
    output logic [SUM_W-1:0] peak_so2,
`endif
    output logic             busy,
    output logic             out_valid,
    output logic [SUM_W-1:0] out_so1,
    output logic [SUM_W-1:0] out_so2,
    output logic             overrun
);

    // The step counter, channel decode and side decode all assume 8 steps,
    // and 4 x 120 = 480 needs at least 9 bits.
    if (STEPS != MIX_STEPS) begin : g_bad_steps
        $error("apu_mix_sequencer: STEPS must be %0d", MIX_STEPS);
    end
    if (SUM_W < 9) begin : g_bad_sum_w
        $error("apu_mix_sequencer: SUM_W must be >= 9");
    end

    localparam step_t STEP_LAST = step_t'(MIX_STEPS - 1);

    mix_state_t        r_state;
    step_t             r_step;
    mix_snap_t         r_snap;
    logic [SUM_W-1:0]  r_acc_so1;
    logic [SUM_W-1:0]  r_acc_so2;
    logic [SUM_W-1:0]  r_out_so1;
    logic [SUM_W-1:0]  r_out_so2;
    logic              r_valid;
    logic              r_overrun;

    logic [1:0]        w_ch;
    logic              w_side;
    logic [AMP_W-1:0]  w_amp;
    logic [LVL_W-1:0]  w_lvl;
    logic              w_en;
    logic [TERM_W-1:0] w_term;
    logic [SUM_W-1:0]  w_term_ext;
    logic              w_unused_vol;

    // Volume bits 3 and 7 carry no meaning for the mixer.
    assign w_unused_vol = ^{ch_volume[7], ch_volume[3]};

    assign w_ch       = r_step[2:1];
    assign w_side     = r_step[0];
    assign w_term_ext = SUM_W'(w_term);
    assign busy       = (r_state != IDLE);

    // Route the current step's channel amplitude, side level and enable to the multiplier.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        w_amp = amp_of(r_snap.amp, w_ch);
        w_lvl = r_snap.lvl_so1;
        w_en  = r_snap.dst[{1'b0, w_ch}];
        if (w_side) begin
            w_lvl = r_snap.lvl_so2;
            w_en  = r_snap.dst[{1'b1, w_ch}];
        end
    end

    mix_term_mul u_mul (
        .amp  (w_amp),
        .lvl  (w_lvl),
        .en   (w_en),
        .term (w_term)
    );

    // Sequencer FSM: accept a request, walk steps 0..7, spend one cycle in DONE.
    always_ff @(posedge clk or negedge n_rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!n_rst) begin
            r_state <= IDLE;
            r_step  <= '0;
            r_snap  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (sample_req) begin
                        r_snap.amp     <= ch_amp;
                        r_snap.lvl_so1 <= ch_volume[2:0];
                        r_snap.lvl_so2 <= ch_volume[6:4];
                        r_snap.dst     <= ch_dst;
                        r_step         <= '0;
                        r_state        <= CALC;
                    end
                end
                CALC: begin
                    r_step <= r_step + step_t'(1);
                    if (r_step == STEP_LAST) begin
                        r_state <= DONE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Accumulators: cleared on acceptance, one side gains a term each CALC step.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_acc_so1 <= '0;
            r_acc_so2 <= '0;
        end else if (r_state == IDLE && sample_req) begin
            r_acc_so1 <= '0;
            r_acc_so2 <= '0;
        end else if (r_state == CALC) begin
            if (w_side) begin
                r_acc_so2 <= r_acc_so2 + w_term_ext;
            end else begin
                r_acc_so1 <= r_acc_so1 + w_term_ext;
            end
        end
    end

    // Output words load on the DONE edge and hold; valid pulses for that one cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_out_so1 <= '0;
            r_out_so2 <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_valid <= (r_state == DONE);
            if (r_state == DONE) begin
                r_out_so1 <= r_acc_so1;
                r_out_so2 <= r_acc_so2;
            end
        end
    end

    // Sticky overrun: a request while busy is dropped and flagged; set beats clear.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_overrun <= 1'b0;
        end else if (sample_req && r_state != IDLE) begin
            r_overrun <= 1'b1;
        end else if (ovr_clr) begin
            r_overrun <= 1'b0;
        end
    end

    assign out_so1   = r_out_so1;
    assign out_so2   = r_out_so2;
    assign out_valid = r_valid;
    assign overrun   = r_overrun;

`ifdef APU_MIX_PEAK_EN
    logic [SUM_W-1:0] r_peak_so1;
    logic [SUM_W-1:0] r_peak_so2;

    // Peak hold: max of peak and new sum on DONE; a coincident clear loads the new sum.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_peak_so1 <= '0;
            r_peak_so2 <= '0;
        end else if (r_state == DONE) begin
            if (peak_clr || r_acc_so1 > r_peak_so1) begin
                r_peak_so1 <= r_acc_so1;
            end
            if (peak_clr || r_acc_so2 > r_peak_so2) begin
                r_peak_so2 <= r_acc_so2;
            end
        end else if (peak_clr) begin
            r_peak_so1 <= '0;
            r_peak_so2 <= '0;
        end
    end

    assign peak_so1 = r_peak_so1;
    assign peak_so2 = r_peak_so2;
`endif

endmodule

// File: tb/tb_apu_mix_sequencer.sv
// tb_apu_mix_sequencer: directed and randomized checks of apu_mix_sequencer
// against a behavioural mix model. Define APU_MIX_PEAK_EN to cover peak hold.
module tb_apu_mix_sequencer;

    localparam int SUM_W = 9;

    logic             clk = 1'b0;
    logic             n_rst = 1'b0;
    logic             sample_req = 1'b0;
    logic [15:0]      ch_amp = '0;
    logic [7:0]       ch_volume = '0;
    logic [7:0]       ch_dst = '0;
    logic             ovr_clr = 1'b0;
    logic             busy;
    logic             out_valid;
    logic [SUM_W-1:0] out_so1;
    logic [SUM_W-1:0] out_so2;
    logic             overrun;
`ifdef APU_MIX_PEAK_EN
    logic             peak_clr = 1'b0;
    logic [SUM_W-1:0] peak_so1;
    logic [SUM_W-1:0] peak_so2;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    apu_mix_sequencer #(.SUM_W(SUM_W), .STEPS(8)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .sample_req (sample_req),
        .ch_amp     (ch_amp),
        .ch_volume  (ch_volume),
        .ch_dst     (ch_dst),
        .ovr_clr    (ovr_clr),
`ifdef APU_MIX_PEAK_EN
        .peak_clr   (peak_clr),
        .peak_so1   (peak_so1),
        .peak_so2   (peak_so2),
`endif
        .busy       (busy),
        .out_valid  (out_valid),
        .out_so1    (out_so1),
        .out_so2    (out_so2),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Step past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural mix: each side sums (level+1)*amp over its enabled channels.
    function automatic void model(input logic [15:0] amp, input logic [7:0] vol,
                                  input logic [7:0] dst, output int so1, output int so2);
        int a;
        so1 = 0;
        so2 = 0;
        for (int c = 0; c < 4; c++) begin
            a = int'((amp >> (4 * c)) & 16'hF);
            if (dst[c])     so1 += (int'(vol & 8'h07) + 1) * a;
            if (dst[c + 4]) so2 += (int'((vol >> 4) & 8'h07) + 1) * a;
        end
    endfunction

    // Present a request for one edge, then scramble the inputs.
    task automatic start_mix(input logic [15:0] amp, input logic [7:0] vol, input logic [7:0] dst);
        sample_req = 1'b1;
        ch_amp     = amp;
        ch_volume  = vol;
        ch_dst     = dst;
        tick();
        sample_req = 1'b0;
        ch_amp     = 16'($urandom);
        ch_volume  = 8'($urandom);
        ch_dst     = 8'($urandom);
    endtask

    // Wait (bounded) for out_valid, then compare both sums with the model.
    task automatic finish_mix(input string tag, input logic [15:0] amp, input logic [7:0] vol,
                              input logic [7:0] dst, output int cycles, output int busy_cycles);
        int e1, e2;
        model(amp, vol, dst, e1, e2);
        cycles      = 0;
        busy_cycles = 0;
        while (!out_valid && cycles < 20) begin
            if (busy) busy_cycles++;
            tick();
            cycles++;
        end
        chk({tag, " valid_seen"}, 32'(out_valid), 32'd1);
        chk({tag, " so1"}, 32'(out_so1), 32'(e1));
        chk({tag, " so2"}, 32'(out_so2), 32'(e2));
    endtask

    initial begin
        int cyc, bcyc;
        logic [15:0] ra;
        logic [7:0]  rv, rd;

        // Reset state
        #12;
        chk("rst so1", 32'(out_so1), 0);
        chk("rst so2", 32'(out_so2), 0);
        chk("rst valid", 32'(out_valid), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst overrun", 32'(overrun), 0);
        n_rst = 1'b1;
        tick();

        // Full scale on both sides: 480/480, 9 busy cycles, valid after E9
        start_mix(16'hFFFF, 8'h77, 8'hFF);
        chk("full busy_after_E0", 32'(busy), 1);
        finish_mix("full", 16'hFFFF, 8'h77, 8'hFF, cyc, bcyc);
        chk("full latency", 32'(cyc), 9);
        chk("full busy_len", 32'(bcyc), 9);
        chk("full so1_480", 32'(out_so1), 480);
        tick();
        chk("full valid_one_cycle", 32'(out_valid), 0);
        chk("full hold_so1", 32'(out_so1), 480);

        // Single channel to SO1 at max and min level
        start_mix(16'h000F, 8'h07, 8'h01);
        finish_mix("p1max", 16'h000F, 8'h07, 8'h01, cyc, bcyc);
        chk("p1max so1_120", 32'(out_so1), 120);
        // Back-to-back: accept in the valid cycle
        start_mix(16'h000F, 8'h00, 8'h01);
        finish_mix("p1min", 16'h000F, 8'h00, 8'h01, cyc, bcyc);
        chk("p1min latency", 32'(cyc), 9);
        chk("p1min so1_15", 32'(out_so1), 15);

        // SO2 only, amplitudes zeroed right after capture
        start_mix(16'h4321, 8'h30, 8'hF0);
        ch_amp = 16'h0000;
        finish_mix("so2", 16'h4321, 8'h30, 8'hF0, cyc, bcyc);
        chk("so2 val_40", 32'(out_so2), 40);

        // Request at step 3 is dropped and flagged
        start_mix(16'h4321, 8'h30, 8'hF0);
        tick(); tick(); tick();
        sample_req = 1'b1;
        ch_amp     = 16'hFFFF;
        ch_volume  = 8'h77;
        ch_dst     = 8'hFF;
        tick();
        sample_req = 1'b0;
        chk("ovr set", 32'(overrun), 1);
        finish_mix("ovr", 16'h4321, 8'h30, 8'hF0, cyc, bcyc);
        chk("ovr latency_unchanged", 32'(cyc), 5);

        // Clear and new overrun in the same cycle: set wins
        start_mix(16'h1234, 8'h52, 8'h5A);
        sample_req = 1'b1;
        ovr_clr    = 1'b1;
        tick();
        sample_req = 1'b0;
        ovr_clr    = 1'b0;
        chk("ovr set_wins", 32'(overrun), 1);
        finish_mix("ovr2", 16'h1234, 8'h52, 8'h5A, cyc, bcyc);
        tick();
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        chk("ovr cleared", 32'(overrun), 0);

        // All-zero panning: zero outputs, same step count
        start_mix(16'hFFFF, 8'h77, 8'h00);
        finish_mix("nodst", 16'hFFFF, 8'h77, 8'h00, cyc, bcyc);
        chk("nodst latency", 32'(cyc), 9);

        // Reset during step 5 with non-zero outputs and overrun set
        start_mix(16'hFFFF, 8'h77, 8'hFF);
        finish_mix("pre_rst", 16'hFFFF, 8'h77, 8'hFF, cyc, bcyc);
        start_mix(16'h9ABC, 8'h61, 8'hC3);
        sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
        tick(); tick(); tick(); tick();
        chk("pre_rst busy", 32'(busy), 1);
        n_rst = 1'b0;
        #1;
        chk("midrst so1", 32'(out_so1), 0);
        chk("midrst so2", 32'(out_so2), 0);
        chk("midrst busy", 32'(busy), 0);
        chk("midrst overrun", 32'(overrun), 0);
        chk("midrst valid", 32'(out_valid), 0);
        #3;
        n_rst = 1'b1;
        bcyc = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) bcyc++;
        end
        chk("postrst no_valid", 32'(bcyc), 0);
        start_mix(16'h9ABC, 8'h61, 8'hC3);
        finish_mix("postrst", 16'h9ABC, 8'h61, 8'hC3, cyc, bcyc);

        // Randomized mixes against the model
        for (int i = 0; i < 8; i++) begin
            ra = 16'($urandom);
            rv = 8'($urandom);
            rd = 8'($urandom);
            start_mix(ra, rv, rd);
            finish_mix($sformatf("rand%0d", i), ra, rv, rd, cyc, bcyc);
            chk($sformatf("rand%0d latency", i), 32'(cyc), 9);
            tick();
        end

`ifdef APU_MIX_PEAK_EN
        // Peak hold: 480 then 40 keeps 480; clear alone; clear coincident with DONE
        peak_clr = 1'b1;
        tick();
        peak_clr = 1'b0;
        start_mix(16'hFFFF, 8'h77, 8'hFF);
        finish_mix("pk480", 16'hFFFF, 8'h77, 8'hFF, cyc, bcyc);
        start_mix(16'h4321, 8'h30, 8'hF0);
        finish_mix("pk40", 16'h4321, 8'h30, 8'hF0, cyc, bcyc);
        chk("peak so1_hold", 32'(peak_so1), 480);
        chk("peak so2_hold", 32'(peak_so2), 480);
        peak_clr = 1'b1;
        tick();
        peak_clr = 1'b0;
        chk("peak clr_so1", 32'(peak_so1), 0);
        chk("peak clr_so2", 32'(peak_so2), 0);
        start_mix(16'hFFFF, 8'h77, 8'hFF);
        finish_mix("pkrefill", 16'hFFFF, 8'h77, 8'hFF, cyc, bcyc);
        start_mix(16'h000F, 8'h07, 8'h01);
        for (int i = 0; i < 8; i++) tick();
        peak_clr = 1'b1;
        tick();
        peak_clr = 1'b0;
        chk("peak coinc_valid", 32'(out_valid), 1);
        chk("peak coinc_so1", 32'(peak_so1), 120);
        chk("peak coinc_so2", 32'(peak_so2), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/apu_mix_sequencer.md
Name: apu_mix_sequencer

Overview:
Time-multiplexed stereo mixer for the APU output stage.
- On each output-sample request it snapshots the four 4-bit channel amplitudes plus the master-volume and panning registers (NR50-style `ch_volume`, NR51-style `ch_dst`).
- It computes gated, scaled left/right sums with one shared 4x4 multiplier over 8 sequenced steps.
- It presents registered SO1/SO2 mix words to the DAC/PWM stage with a one-cycle valid strobe.

Parameters:
- `SUM_W`, 9, width of each output sum. Must be >= 9, since 4 x (8 x 15) = 480.
- `STEPS`, 8, number of multiply steps (4 channels x 2 sides). Fixed; any other value is illegal and is caught by an elaboration assertion.

Ports:
- `clk`  in  1  system clock
- `n_rst`  in  1  asynchronous active-low reset
- `sample_req`  in  1  single-cycle request to produce a new mixed sample
- `ch_amp`  in  16  channel amplitudes {noise[15:12], pattern[11:8], pulse2[7:4], pulse1[3:0]}
- `ch_volume`  in  8  [2:0] SO1 master level, [6:4] SO2 master level, [3] and [7] ignored
- `ch_dst`  in  8  [3:0] per-channel enable to SO1, [7:4] per-channel enable to SO2
- `ovr_clr`  in  1  clears the sticky overrun flag
- `busy`  out  1  high while a mix is in progress
- `out_valid`  out  1  one-cycle strobe: new `out_so1`/`out_so2` values are present
- `out_so1`  out  SUM_W  SO1 (right) mix
- `out_so2`  out  SUM_W  SO2 (left) mix
- `overrun`  out  1  sticky flag: a request arrived while busy

Behaviour:
- Reset (async, `n_rst`=0): state IDLE, step=0, both accumulators=0. `out_so1`=0, `out_so2`=0, `out_valid`=0, `busy`=0, `overrun`=0. Snapshot registers are cleared to 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - If `sample_req`=1 on an edge: latch `ch_amp`, `ch_volume`, `ch_dst` into the snapshot; clear both accumulators; set step=0; go to CALC.
  - Inputs may change freely after that edge.
- CALC: one step per edge, step 0..7.
  - Channel = step[2:1] (0 = pulse1 .. 3 = noise). Side = step[0] (0 = SO1, 1 = SO2).
  - term = dst_bit ? (lvl + 1) * amp : 0. Here `lvl` is 3 bits, so `lvl`+1 is 4 bits (range 1..8); `amp` is 4 bits; the term is 7 bits, max 120.
  - The term is added into that side's accumulator, zero-extended to SUM_W. No saturation is needed.
  - On step 7, go to DONE.
- DONE (one cycle): on the next edge, load `out_so1`/`out_so2` from the accumulators, pulse `out_valid`=1 for exactly one cycle, return to IDLE.
- Latency: `sample_req` sampled at edge E0; `out_valid` is high during the cycle after edge E9. Edges E1..E8 are the steps; E9 is the DONE edge.
- `busy` = (state != IDLE). It is combinational from the state register and is high from after E0 until E9.
- A new request is accepted in the cycle `out_valid` is high (state is IDLE). Back-to-back throughput is one sample per 10 cycles.
- `sample_req` while `busy`: the request is dropped, the mix in progress is unaffected, and `overrun` is set.
  - `ovr_clr` clears `overrun`.
  - If `ovr_clr` and a new overrun occur in the same cycle, set wins.
- `out_so1`/`out_so2` hold their values until the next DONE.
- Reset asserted mid-mix: immediate return to reset values. No `out_valid` is produced for the aborted sample.
- All-zero `ch_dst` produces 0/0 outputs. The step count is unchanged.

Optional Feature:
- Macro: `APU_MIX_PEAK_EN`.
- With the macro defined:
  - Adds ports `peak_clr` (in, 1), `peak_so1` (out, SUM_W) and `peak_so2` (out, SUM_W).
  - On each DONE edge, each peak register becomes max(peak, new sum).
  - `peak_clr` zeroes both peaks. If `peak_clr` coincides with a DONE, the peaks load the new sums.
  - Peaks reset to 0.
- Without the macro: these ports and registers do not exist, and behaviour is otherwise identical.

Decomposition:
- Package `apu_mix_pkg` holds:
  - `mix_state_t` enum {IDLE, CALC, DONE}
  - `step_t` (logic [2:0])
  - constants `AMP_W`=4, `LVL_W`=3, `TERM_W`=7, `MIX_STEPS`=8
  - channel index constants `CH_PULSE1`..`CH_NOISE`
- One sub-module, `mix_term_mul`. It is purely combinational: inputs amp[3:0], lvl[2:0], en; output term[6:0]. It is instantiated once and shared across all steps.

Test Plan:
- All amps 15, `ch_volume`=0x77, `ch_dst`=0xFF, one `sample_req` -> `out_valid` in the cycle after the 9th edge following capture; `out_so1`=480, `out_so2`=480; `busy` high for exactly 9 cycles.
- amps {0,0,0,15}, `ch_volume`=0x07, `ch_dst`=0x01 -> `out_so1`=120, `out_so2`=0. Then with `ch_volume`=0x00 -> `out_so1`=15.
- amps {4,3,2,1} (noise..pulse1), `ch_volume`=0x30, `ch_dst`=0xF0 -> `out_so2`=4*(1+2+3+4)=40, `out_so1`=0. Change `ch_amp` to 0 right after capture -> result still 40.
- Pulse `sample_req` again at step 3 -> result unchanged, `overrun`=1. `ovr_clr` and a new overrun in the same cycle -> `overrun` stays 1. `ovr_clr` alone -> 0.
- Drop `n_rst` during step 5 -> all outputs 0 immediately, no `out_valid`. After release, a new request produces a correct result.
- With `APU_MIX_PEAK_EN`: mixes of 480, then 40 -> `peak_so1` stays 480. `peak_clr` alone -> 0. `peak_clr` coincident with a DONE of 120 -> 120.
